// File: rtl/uart_pkt_deframer.sv
// uart_pkt_deframer: packet deframer behind a UART receiver.
// Hunts for SYNC, LEN, LEN payload bytes, CHECKSUM; buffers the payload and
// releases it on a valid/ready byte stream only once the checksum verifies.
// Bad, corrupted or stalled frames are discarded and reported on error strobes.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_data       - received byte, qualified by i_data_vld (one-cycle strobe)
//   o_data       - payload byte, 0 when o_data_vld is low
//   o_data_vld   - payload byte valid; handshake with i_data_rdy
//   o_last       - final payload byte of the frame (qualified by o_data_vld)
//   o_len_err    - pulse: illegal LEN byte
//   o_crc_err    - pulse: checksum mismatch
//   o_to_err     - pulse: inter-byte timeout inside a frame
//   o_drop       - pulse: input byte discarded while draining
module uart_pkt_deframer #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_data_vld,
    output logic [7:0] o_data,
    output logic       o_data_vld,
    input  logic       i_data_rdy,
    output logic       o_last,
    output logic       o_len_err,
    output logic       o_crc_err,
    output logic       o_to_err,
    output logic       o_drop
);

    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [7:0]    MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit            TO_EN      = (TIMEOUT > 0);

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      sum_q, sum_d;
    logic [TW-1:0]   idle_q, idle_d;
    logic [7:0]      sum_add;
    logic            hs;
    logic            wr_en;
    logic [7:0]      data_d;
    logic            vld_d, last_d;
    logic            len_err_d, crc_err_d, to_err_d, drop_d;

    logic [7:0]      pay_buf [MAX_LEN];

    assign hs      = o_data_vld & i_data_rdy;
    assign sum_add = sum_q + i_data;

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_cnt_d  = wr_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        sum_d     = sum_q;
        idle_d    = idle_q;
        wr_en     = 1'b0;
        len_err_d = 1'b0;
        crc_err_d = 1'b0;
        to_err_d  = 1'b0;
        drop_d    = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (i_data_vld && (i_data == SYNC)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (i_data_vld) begin
                    if ((i_data == 8'd0) || (i_data > MAX_LEN_B)) begin
                        len_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d    = LW'(i_data);
                        wr_cnt_d = '0;
                        sum_d    = i_data;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // SYNC here is plain data: no resynchronisation mid-frame
                if (i_data_vld) begin
                    wr_en    = 1'b1;
                    sum_d    = sum_add;
                    wr_cnt_d = wr_cnt_q + LW'(1);
                    if (wr_cnt_q == (len_q - LW'(1))) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (i_data_vld) begin
                    if (sum_add == 8'd0) begin
                        rd_ptr_d = '0;
                        state_d  = ST_DRAIN;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_DRAIN: begin
                // No backpressure upstream: bytes arriving now are lost
                drop_d = i_data_vld;
                if (hs) begin
                    if (o_last) begin
                        rd_ptr_d = '0;
                        state_d  = ST_HUNT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + LW'(1);
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Inter-byte idle timer; a byte on the expiry cycle wins
        if (TO_EN && !i_data_vld &&
            ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM))) begin
            if (idle_q == IDLE_LIMIT) begin
                to_err_d = 1'b1;
                state_d  = ST_HUNT;
            end else begin
                idle_d = idle_q + TW'(1);
            end
        end
        if (i_data_vld || (state_d != state_q)) begin
            idle_d = '0;
        end

        vld_d  = (state_d == ST_DRAIN);
        data_d = vld_d ? pay_buf[AW'(rd_ptr_d)] : 8'h00;
        last_d = vld_d && (rd_ptr_d == (len_q - LW'(1)));
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HUNT;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            sum_q      <= '0;
            idle_q     <= '0;
            o_data     <= '0;
            o_data_vld <= 1'b0;
            o_last     <= 1'b0;
            o_len_err  <= 1'b0;
            o_crc_err  <= 1'b0;
            o_to_err   <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            sum_q      <= sum_d;
            idle_q     <= idle_d;
            o_data     <= data_d;
            o_data_vld <= vld_d;
            o_last     <= last_d;
            o_len_err  <= len_err_d;
            o_crc_err  <= crc_err_d;
            o_to_err   <= to_err_d;
            o_drop     <= drop_d;
        end
    end

    // Payload buffer: not reset, always written before it is read
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            pay_buf[AW'(wr_cnt_q)] <= i_data;
        end
    end

endmodule

// File: doc/uart_pkt_deframer.md
# uart_pkt_deframer

Packet deframer sitting directly downstream of the UART receiver. Consumes its single-cycle byte strobes, hunts for frames of the form SYNC, LEN, LEN payload bytes and CHECKSUM, and buffers the payload. Releases the payload on a valid/ready byte stream only after the checksum verifies. Malformed, corrupted or stalled frames are discarded and reported on single-cycle error strobes.

## Interface
- `SYNC`, 8'hA5: frame start byte.
- `MAX_LEN`, 16: maximum payload length. Legal range 1..255; sets the depth of the payload buffer.
- `TIMEOUT`, 1000: idle clock cycles allowed between bytes inside a frame. 0 disables the timeout.

Ports:
- `clk`  in  1: single clock for the block.
- `rst`  in  1: reset. Synchronous and active-high.
- `i_data`  in  8: received byte. Sampled only when `i_data_vld` is 1.
- `i_data_vld`  in  1: one-cycle byte strobe from the UART receiver. There is no backpressure toward the receiver.
- `o_data`  out  8: payload byte. Equals 0 whenever `o_data_vld` is 0.
- `o_data_vld`  out  1: payload byte valid.
- `i_data_rdy`  in  1: downstream ready. A handshake occurs when `o_data_vld` and `i_data_rdy` are both 1.
- `o_last`  out  1: marks the final payload byte of a frame. Qualified by `o_data_vld`.
- `o_len_err`  out  1: one-cycle pulse on an illegal LEN byte.
- `o_crc_err`  out  1: one-cycle pulse on a checksum mismatch.
- `o_to_err`  out  1: one-cycle pulse on an inter-byte timeout.
- `o_drop`  out  1: one-cycle pulse when an input byte arrives in DRAIN and is discarded.

## Operation
- State machine states: HUNT, LEN, PAYLOAD, CSUM, DRAIN. Reset state is HUNT.
- **HUNT:** a byte equal to `SYNC` moves to LEN. Every other byte is ignored silently.
- **LEN:** on a byte:
  - If the byte is 0 or greater than `MAX_LEN`: pulse `o_len_err`, go to HUNT.
  - Otherwise: `len <= byte`, `wr_cnt <= 0`, `sum <= byte`, go to PAYLOAD.
- **PAYLOAD:** on a byte:
  - `buf[wr_cnt] <= byte`, `sum <= sum + byte` (mod 256), `wr_cnt++`.
  - The byte with `wr_cnt == len-1` moves to CSUM.
  - A byte equal to `SYNC` in this state is treated as data; there is no resync.
- **CSUM:** on a byte:
  - If `(sum + byte) mod 256 == 0`: `rd_ptr <= 0`, go to DRAIN.
  - Otherwise: pulse `o_crc_err`, go to HUNT.
  - The sender therefore transmits the two's complement of the 8-bit sum of LEN and the payload.
- **DRAIN:**
  - `o_data_vld = 1`, `o_data = buf[rd_ptr]`, `o_last = (rd_ptr == len-1)`.
  - Each handshake increments `rd_ptr`.
  - The handshake with `o_last` high returns the FSM to HUNT.
  - Every `i_data_vld` in DRAIN pulses `o_drop` and the byte is discarded, including SYNC.
- **Timeout:**
  - The idle counter clears on every accepted byte and on every state entry.
  - It counts only in LEN, PAYLOAD and CSUM.
  - When it reaches `TIMEOUT-1` with no byte that cycle: pulse `o_to_err`, go to HUNT.
  - If a byte and the timeout land on the same cycle, the byte wins.
- **Widths:**
  - `wr_cnt`, `rd_ptr` and `len` are `$clog2(MAX_LEN+1)` bits.
  - `sum` is 8 bits and wraps.
  - The idle counter is `$clog2(TIMEOUT+1)` bits.
- **Buffer:** register array of `MAX_LEN` x 8. Contents are undefined after reset and are never read before being written.

## Timing
- **Reset values:** `o_data_vld`, `o_last`, `o_len_err`, `o_crc_err`, `o_to_err` and `o_drop` are all 0; `o_data` is 0. State is HUNT and all counters are 0.
- **Reset mid-frame:** any partial frame is abandoned, no error is pulsed, and the next cycle is in HUNT.
- **State updates:** each state transition takes effect on the clock edge that samples the byte. One byte per strobe.
- **Error strobes:** registered; each is high for exactly one cycle, the cycle after the offending byte or timeout edge.
- **Payload latency:** `o_data_vld` rises in the cycle after the CHECKSUM byte is sampled.
- **Output stability:** while `i_data_rdy` is 0, `o_data` and `o_last` hold stable.
- **Throughput:** one byte per cycle with `i_data_rdy` held at 1. A frame of length N drains in exactly N cycles.
- **After the last byte:** `o_data_vld` drops in the cycle after the last handshake. A SYNC sampled in that same cycle, which is in HUNT, is accepted.

## Test plan
- **Good frame:** feed A5 03 11 22 33 97 with `i_data_rdy` = 1.
  - Expect `o_data` = 11, 22, 33 on 3 consecutive cycles, starting 1 cycle after 97 is sampled.
  - Expect `o_last` on 33 only, and no error pulses.
- **Illegal LEN:** feed A5 00, then A5 11 (with `MAX_LEN` = 16).
  - Expect one `o_len_err` pulse for each frame and no output.
  - A following good frame is then delivered intact.
- **Bad checksum:** feed A5 03 11 22 33 98.
  - Expect one `o_crc_err` pulse and `o_data_vld` never asserted.
  - Garbage bytes 00 FF placed before the next A5 are ignored.
- **Backpressure and drop:**
  - Run the good frame with `i_data_rdy` pattern 0,0,1,0,1,1: bytes 11, 22, 33 are delivered in order and hold stable while ready is low.
  - Two input strobes during DRAIN each give an `o_drop` pulse and do not start a frame.
- **Timeout:** with `TIMEOUT` = 8, feed A5 03 11, then go idle.
  - Expect `o_to_err` 8 cycles after the 11 byte.
  - A following full good frame is delivered correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle after A5 02 44.
  - Expect all outputs 0 and no error pulse.
  - A5 01 55 AA is then accepted and outputs 55 with `o_last` = 1.
